// File: rtl/imem_loader.sv
// Boot loader: LEN_LO, LEN_HI, 4*N little-endian payload bytes and an XOR checksum byte.
// The words go into instruction memory, then cpu_reset is released. Optional idle timeout: LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] word_q, word_d;
  logic        xfer;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Every state except S_DONE accepts bytes. S_ERR accepts them only to discard them.
  assign byte_ready = (state_q != S_DONE);
  assign xfer       = byte_valid && byte_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    csum_d       = csum_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          if (32'({byte_data, len_q[7:0]}) > DEPTH_WORDS) state_d = S_ERR;
          else if ({byte_data, len_q[7:0]} == 16'd0)     state_d = S_CSUM;
          else                                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_wdata_d = {byte_data, word_q};
              imem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
              idx_d        = idx_q + 16'd1;
              if (idx_q == len_q - 16'd1) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase

`ifdef LOADER_TIMEOUT_EN
    idle_d = 32'd0;
    if ((state_q == S_LEN1 || state_q == S_DATA || state_q == S_CSUM) && !xfer) begin
      if (idle_q == TIMEOUT_CYCLES) state_d = S_ERR;
      else                          idle_d  = idle_q + 32'd1;
    end
`endif

    // The status outputs are registered copies of the next state. They change on the same edge as the FSM.
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      lane_q       <= 2'd0;
      csum_q       <= 8'd0;
      word_q       <= 24'd0;
`ifdef LOADER_TIMEOUT_EN
      idle_q       <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
`ifdef LOADER_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Verifies an XOR checksum, then releases the core from reset.
- Sits between the host link (UART RX or testbench) and the instruction memory write port; its cpu_reset output drives the processor's reset input.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; maximum accepted length.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- TIMEOUT_CYCLES, 1000, idle-cycle limit between bytes; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready at a rising edge.
- imem_we  output  1  one-cycle instruction memory write strobe.
- imem_addr  output  32  byte address of the write, word aligned.
- imem_wdata  output  32  word to write.
- cpu_reset  output  1  holds the processor in reset while high.
- done  output  1  load completed and checksum matched.
- error  output  1  load failed; sticky until reset.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All outputs are registered except byte_ready, which decodes from state.
- Reset values:
  - state=S_LEN0, byte_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - word count, byte lane, word index and checksum accumulator all 0.
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, each word little-endian (first byte = bits 7:0).
  - One CSUM byte: XOR of all payload bytes. Length bytes are excluded.
- FSM states: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR.
  - S_LEN0: accept LEN_LO, go to S_LEN1.
  - S_LEN1: accept LEN_HI.
    - If N > DEPTH_WORDS, go to S_ERR.
    - Else if N == 0, go to S_CSUM.
    - Else go to S_DATA.
  - S_DATA: each accepted byte shifts into lane 0..3 and XORs into the accumulator.
    - On acceptance of lane 3, the next cycle carries imem_we=1 for exactly one cycle, with imem_addr=BASE_ADDR+4*index and imem_wdata=assembled word.
    - The word index then increments and the lane wraps to 0.
    - After word N-1 is accepted, go to S_CSUM.
  - S_CSUM: accept one byte.
    - If it equals the accumulator, go to S_DONE; else go to S_ERR.
    - For N=0, the expected checksum is 8'h00.
  - S_DONE: done=1, cpu_reset=0 from the first S_DONE cycle, byte_ready=0. The state is held until reset.
  - S_ERR: error=1, cpu_reset=1, byte_ready=1; all further bytes are discarded. The state is held until reset.
- Throughput and timing:
  - byte_ready=1 in S_LEN0, S_LEN1, S_DATA and S_CSUM, so one byte is accepted per cycle; back-to-back streaming has no bubbles.
  - A write strobe may coincide with acceptance of the next word's first byte; this is legal.
  - Latency: the write strobe occurs 1 cycle after the 4th byte of the word. done rises 1 cycle after the CSUM byte.
- Boundary conditions:
  - byte_valid=0 stalls without state change.
  - N == DEPTH_WORDS is legal; the last address is BASE_ADDR+4*(DEPTH_WORDS-1).
  - byte_data is ignored whenever byte_valid=0.
  - Reset asserted mid-load returns every register to its reset value on that edge. Any pending write strobe is cancelled (imem_we=0), and cpu_reset stays 1.
  - done and error are never high together.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- When defined:
  - An idle counter runs in S_LEN1, S_DATA and S_CSUM. It clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES consecutive cycles without a transfer, the FSM goes to S_ERR on the next edge.
  - S_LEN0 never times out.
- When undefined: no counter exists, the TIMEOUT_CYCLES parameter is unused, and the loader waits indefinitely.

Test Plan:
- Nominal load: stream 02 00 | 13 05 A0 00 | 93 05 B0 00 | CSUM=8'h00^(13^05^A0^00^93^05^B0^00). Required response:
  - imem_we pulses at 32'h0 with 32'h00A00513, then at 32'h4 with 32'h00B00593.
  - done=1 and cpu_reset=0 one cycle after CSUM.
- Bad checksum: same stream with CSUM^8'h01 -> no done; error=1, cpu_reset=1, byte_ready stays 1 and later bytes produce no imem_we.
- Oversize: DEPTH_WORDS=64 with LEN bytes 41 00 (N=65) -> error=1 the cycle after LEN_HI; no write strobe ever.
- Zero length: stream 00 00 00 -> done=1, zero writes. Stream 00 00 5A -> error=1.
- Gapped stream plus mid-load reset: insert random byte_valid=0 gaps and confirm writes are identical to the nominal case. Then assert reset after 5 payload bytes:
  - All outputs return to reset values.
  - A fresh nominal load rewrites from 32'h0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: stop after 3 payload bytes -> error=1 after 16 idle cycles. Idling 100 cycles in S_LEN0 produces no error.
